spimem_cache: RTL and testbench

Direct-mapped, single-word-per-line read cache between the PicoRV32 instruction/data memory port and `spimemio`, the on-chip flash-image ROM reader. It serves repeated reads of the flash window (1 MB base, 8 KB image) in one cycle instead of the 3+ cycle ROM round trip. Addresses outside the window pass through uncached. It also provides a flush input and saturating hit/miss counters for firmware profiling.

---
 rtl/spimem_cache_if.sv | 31 +++
 rtl/spimem_cache.sv | 146 ++++++++++++++
 tb/tb_spimem_cache.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/spimem_cache_if.sv
// ---------------------------------------------------------------------------
// spimem_cache_if
// Bus bundle between the CPU memory port, the cache and spimemio.
//   up_valid/up_addr        CPU read request (held until up_ready)
//   up_ready/up_rdata       one-cycle response strobe and read data
//   dn_valid/dn_addr        word-aligned request towards spimemio
//   dn_ready/dn_rdata       spimemio completion strobe and data
// Modports:
//   slave  - the cache itself
//   master - the surrounding system (CPU side plus spimemio side)
// ---------------------------------------------------------------------------
interface spimem_cache_if;
    logic        up_valid;
    logic        up_ready;
    logic [23:0] up_addr;
    logic [31:0] up_rdata;
    logic        dn_valid;
    logic        dn_ready;
    logic [23:0] dn_addr;
    logic [31:0] dn_rdata;

    modport slave (
        input  up_valid, up_addr, dn_ready, dn_rdata,
        output up_ready, up_rdata, dn_valid, dn_addr
    );

    modport master (
        output up_valid, up_addr, dn_ready, dn_rdata,
        input  up_ready, up_rdata, dn_valid, dn_addr
    );
endinterface

// File: rtl/spimem_cache.sv
// ---------------------------------------------------------------------------
// spimem_cache
// Direct-mapped, one-word-per-line read cache in front of spimemio. Reads of
// the flash window (addr[23:20] == BASE_M, addr[19:0] < SIZE_BYTES) hit in
// one cycle once cached; every other address is forwarded uncached.
// Ports:
//   clk       single clock
//   reset     synchronous, active-high reset
//   bus       up_* / dn_* handshake bundle (slave side)
//   flush     invalidate all lines in the cycle it is sampled
//   hit_cnt   saturating count of cacheable hits
//   miss_cnt  saturating count of cacheable misses
// ---------------------------------------------------------------------------
module spimem_cache #(
    parameter int unsigned ENTRIES    = 16,
    parameter logic [3:0]  BASE_M     = 4'h1,
    parameter int unsigned SIZE_BYTES = 8192
) (
    input  logic                 clk,
    input  logic                 reset,
    spimem_cache_if.slave        bus,
    input  logic                 flush,
    output logic [15:0]          hit_cnt,
    output logic [15:0]          miss_cnt
);
    localparam int IW = $clog2(ENTRIES);
    localparam int TW = 22 - IW;

    typedef enum logic [1:0] {IDLE, HIT, FILL, GAP} state_t;

    state_t             state_q, state_d;
    logic [ENTRIES-1:0] valid_q;
    logic [TW-1:0]      tag_q  [ENTRIES];
    logic [31:0]        data_q [ENTRIES];
    logic [31:0]        rdata_q;
    logic [23:0]        dn_addr_q;
    logic               cacheable_q;
    logic               noalloc_q;   // a flush was seen during this fill
    logic               drop_q;      // CPU abandoned this request
    logic [15:0]        hit_cnt_q, miss_cnt_q;

    // Byte-offset bits never influence a lookup.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.up_addr[1:0];

    // Lookup side: combinational read of the line addressed by the request.
    logic [IW-1:0] up_idx;
    logic [TW-1:0] up_tag;
    logic          up_cacheable;
    logic          lookup_hit;

    assign up_idx       = bus.up_addr[IW+1:2];
    assign up_tag       = bus.up_addr[23:IW+2];
    assign up_cacheable = (bus.up_addr[23:20] == BASE_M) &&
                          ({12'd0, bus.up_addr[19:0]} < SIZE_BYTES);
    // A coincident flush wins over the lookup, so the request misses.
    assign lookup_hit   = up_cacheable && valid_q[up_idx] &&
                          (tag_q[up_idx] == up_tag) && !flush;

    // Fill side: the line being refilled is addressed by the latched dn_addr.
    logic [IW-1:0] fill_idx;
    logic [TW-1:0] fill_tag;
    logic          accept;
    logic          fill_done;
    logic          deliver;
    logic          line_wr;

    assign fill_idx  = dn_addr_q[IW+1:2];
    assign fill_tag  = dn_addr_q[23:IW+2];
    assign accept    = (state_q == IDLE) && bus.up_valid;
    assign fill_done = (state_q == FILL) && bus.dn_ready;
    assign deliver   = !drop_q && bus.up_valid;
    assign line_wr   = fill_done && cacheable_q && !noalloc_q && !flush && !reset;

    // Next-state logic. A completed fill reuses HIT to present the response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.up_valid) state_d = lookup_hit ? HIT : FILL;
            HIT:  state_d = GAP;
            FILL: if (bus.dn_ready) state_d = deliver ? HIT : GAP;
            GAP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.up_ready = (state_q == HIT);
    assign bus.up_rdata = rdata_q;
    assign bus.dn_valid = (state_q == FILL);
    assign bus.dn_addr  = dn_addr_q;
    assign hit_cnt      = hit_cnt_q;
    assign miss_cnt     = miss_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rdata_q     <= 32'd0;
            dn_addr_q   <= 24'd0;
            cacheable_q <= 1'b0;
            noalloc_q   <= 1'b0;
            drop_q      <= 1'b0;
            hit_cnt_q   <= 16'd0;
            miss_cnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cacheable_q <= up_cacheable;
                noalloc_q   <= 1'b0;
                drop_q      <= 1'b0;
                if (lookup_hit) begin
                    rdata_q <= data_q[up_idx];
                    if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
                end else begin
                    // Uncached reads also need the downstream address.
                    dn_addr_q <= {bus.up_addr[23:2], 2'b00};
                    if (up_cacheable && miss_cnt_q != 16'hFFFF)
                        miss_cnt_q <= miss_cnt_q + 16'd1;
                end
            end
            if (state_q == FILL) begin
                if (flush)         noalloc_q <= 1'b1;
                if (!bus.up_valid) drop_q    <= 1'b1;
                // An abandoned request leaves up_rdata at its last value.
                if (bus.dn_ready && deliver) rdata_q <= bus.dn_rdata;
            end
        end
    end

    // Tag/data storage needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (line_wr) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= bus.dn_rdata;
        end
    end

    // Valid bits are flops so that flush can clear them all in one cycle.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_valid
        always_ff @(posedge clk) begin
            if (reset || flush)
                valid_q[gi] <= 1'b0;
            else if (line_wr && (fill_idx == IW'(gi)))
                valid_q[gi] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spimem_cache.sv
module tb_spimem_cache;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [15:0] hit_cnt, miss_cnt;

    spimem_cache_if bus();

    spimem_cache #(.ENTRIES(16), .BASE_M(4'h1), .SIZE_BYTES(8192)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .flush    (flush),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp   = 0;
    int          n_fail  = 0;
    int          fetches = 0;
    int          pulses  = 0;
    logic [23:0] last_dn_addr = 24'd0;

    // ROM image model: one distinctive word, everything else encodes its address.
    function automatic logic [31:0] rom(input logic [23:0] a);
        if (a == 24'h100000) return 32'hDEADBEEF;
        return {8'hC5, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // spimemio model: dn_ready in the 4th cycle of dn_valid, one cycle wide.
    initial begin
        int cnt;
        cnt = 0;
        bus.dn_ready = 1'b0;
        bus.dn_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.dn_ready) begin
                bus.dn_ready = 1'b0;
                cnt = 0;
            end else if (bus.dn_valid) begin
                cnt++;
                if (cnt > 3) begin
                    bus.dn_ready = 1'b1;
                    bus.dn_rdata = rom(bus.dn_addr);
                    last_dn_addr = bus.dn_addr;
                    fetches++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    always @(negedge clk) if (bus.up_ready === 1'b1) pulses++;

    // Issue one read at a negedge in IDLE; returns at the next IDLE negedge.
    // flush_cyc: cycle (0 = with request) in which flush is held high, -1 none.
    task automatic do_read(input logic [23:0] addr, input int flush_cyc,
                           output logic [31:0] data, output int lat, output logic first_dn);
        int cyc;
        cyc = 0;
        lat = -1;
        data = 32'hx;
        first_dn = 1'b0;
        bus.up_valid = 1'b1;
        bus.up_addr  = addr;
        flush = (flush_cyc == 0);
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            flush = (cyc == flush_cyc);
            if (cyc == 1) first_dn = bus.dn_valid;
            if (bus.up_ready) begin
                data = bus.up_rdata;
                lat = cyc;
                break;
            end
        end
        bus.up_valid = 1'b0;
        flush = 1'b0;
        if (lat < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: no up_ready for addr %h within 40 cycles", addr);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [23:0] addr;
        int          flush_cyc;
        logic [31:0] data;
        int          lat;
        int          hits;
        int          misses;
        int          fetch;
        logic [23:0] dn_addr;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic [31:0] d;
        int          lat;
        logic        fdn;
        int          p0;
        int          waited;

        vecs[0]  = '{24'h100000, -1, 32'hDEADBEEF, 5, 0, 1, 1,  24'h100000};
        vecs[1]  = '{24'h100000, -1, 32'hDEADBEEF, 1, 1, 1, 1,  24'h0};
        vecs[2]  = '{24'h100040, -1, 32'hC5100040, 5, 1, 2, 2,  24'h100040};
        vecs[3]  = '{24'h100000, -1, 32'hDEADBEEF, 5, 1, 3, 3,  24'h100000};
        vecs[4]  = '{24'h000200, -1, 32'hC5000200, 5, 1, 3, 4,  24'h000200};
        vecs[5]  = '{24'h000200, -1, 32'hC5000200, 5, 1, 3, 5,  24'h000200};
        vecs[6]  = '{24'h101FFC, -1, 32'hC5101FFC, 5, 1, 4, 6,  24'h101FFC};
        vecs[7]  = '{24'h101FFF, -1, 32'hC5101FFC, 1, 2, 4, 6,  24'h0};
        vecs[8]  = '{24'h102000, -1, 32'hC5102000, 5, 2, 4, 7,  24'h102000};
        vecs[9]  = '{24'h200000, -1, 32'hC5200000, 5, 2, 4, 8,  24'h200000};
        vecs[10] = '{24'h100000, -1, 32'hDEADBEEF, 1, 3, 4, 8,  24'h0};
        vecs[11] = '{24'h101FFC,  0, 32'hC5101FFC, 5, 3, 5, 9,  24'h101FFC};
        vecs[12] = '{24'h101FFC, -1, 32'hC5101FFC, 1, 4, 5, 9,  24'h0};
        vecs[13] = '{24'h100008,  2, 32'hC5100008, 5, 4, 6, 10, 24'h100008};
        vecs[14] = '{24'h100008, -1, 32'hC5100008, 5, 4, 7, 11, 24'h100008};
        vecs[15] = '{24'h100008, -1, 32'hC5100008, 1, 5, 7, 11, 24'h0};
        vecs[16] = '{24'h100000, -1, 32'hDEADBEEF, 5, 5, 8, 12, 24'h100000};

        reset = 1'b1;
        flush = 1'b0;
        bus.up_valid = 1'b0;
        bus.up_addr  = 24'd0;
        repeat (3) @(negedge clk);
        check("reset up_ready", {31'd0, bus.up_ready}, 32'd0);
        check("reset up_rdata", bus.up_rdata, 32'd0);
        check("reset dn_valid", {31'd0, bus.dn_valid}, 32'd0);
        check("reset dn_addr", {8'd0, bus.dn_addr}, 32'd0);
        check("reset hit_cnt", {16'd0, hit_cnt}, 32'd0);
        check("reset miss_cnt", {16'd0, miss_cnt}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            do_read(vecs[i].addr, vecs[i].flush_cyc, d, lat, fdn);
            $display("vec %0d: addr %h flush_cyc %0d -> data %h lat %0d hit %0d miss %0d fetches %0d",
                     i, vecs[i].addr, vecs[i].flush_cyc, d, lat, hit_cnt, miss_cnt, fetches);
            check($sformatf("vec%0d data", i), d, vecs[i].data);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d dn_valid cycle1", i), {31'd0, fdn}, (vecs[i].lat != 1) ? 32'd1 : 32'd0);
            check($sformatf("vec%0d hit_cnt", i), {16'd0, hit_cnt}, vecs[i].hits);
            check($sformatf("vec%0d miss_cnt", i), {16'd0, miss_cnt}, vecs[i].misses);
            check($sformatf("vec%0d fetches", i), fetches, vecs[i].fetch);
            if (vecs[i].lat != 1)
                check($sformatf("vec%0d dn_addr", i), {8'd0, last_dn_addr}, {8'd0, vecs[i].dn_addr});
        end

        // CPU drops up_valid mid-fill: no response pulse, line still written.
        p0 = pulses;
        bus.up_valid = 1'b1;
        bus.up_addr  = 24'h100010;
        @(negedge clk);
        @(negedge clk);
        bus.up_valid = 1'b0;
        waited = 0;
        while (bus.dn_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("drop fill finished", {31'd0, bus.dn_valid}, 32'd0);
        @(negedge clk);
        $display("drop: addr 100010 abandoned, pulses %0d -> %0d, miss %0d", p0, pulses, miss_cnt);
        check("drop no up_ready", pulses, p0);
        check("drop miss_cnt", {16'd0, miss_cnt}, 32'd9);
        check("drop fetches", fetches, 13);
        do_read(24'h100010, -1, d, lat, fdn);
        $display("reread 100010: data %h lat %0d", d, lat);
        check("drop reread data", d, 32'hC5100010);
        check("drop reread latency", lat, 1);
        check("drop reread hit_cnt", {16'd0, hit_cnt}, 32'd6);

        // Cache 0x100020, then reset exactly when dn_ready arrives for 0x100030.
        do_read(24'h100020, -1, d, lat, fdn);
        do_read(24'h100020, -1, d, lat, fdn);
        $display("prime 100020: data %h lat %0d", d, lat);
        check("prime hit latency", lat, 1);
        p0 = pulses;
        bus.up_valid = 1'b1;
        bus.up_addr  = 24'h100030;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.dn_ready && waited < 20);
        check("reset-test dn_ready seen", {31'd0, bus.dn_ready}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("reset-test dn_valid", {31'd0, bus.dn_valid}, 32'd0);
        check("reset-test up_ready", {31'd0, bus.up_ready}, 32'd0);
        check("reset-test up_rdata", bus.up_rdata, 32'd0);
        check("reset-test dn_addr", {8'd0, bus.dn_addr}, 32'd0);
        check("reset-test miss_cnt", {16'd0, miss_cnt}, 32'd0);
        reset = 1'b0;
        bus.up_valid = 1'b0;
        repeat (3) @(negedge clk);
        $display("reset-test: pulses %0d -> %0d", p0, pulses);
        check("reset-test no pulse", pulses, p0);
        do_read(24'h100020, -1, d, lat, fdn);
        $display("after reset 100020: data %h lat %0d miss %0d", d, lat, miss_cnt);
        check("post-reset data", d, 32'hC5100020);
        check("post-reset latency", lat, 5);
        check("post-reset miss_cnt", {16'd0, miss_cnt}, 32'd1);
        check("post-reset hit_cnt", {16'd0, hit_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
